multiplier_datapath: RTL and testbench
======================================

Name: multiplier_datapath

Overview:
Register and arithmetic datapath for the shift-add 8-bit signed multiplier. It sits directly downstream of the multiplier control FSM and consumes that FSM's Shift, ADD, SUB, Clr_Ld and Clear_A strobes. It holds the sign-extension bit X, the accumulator A (upper product) and the multiplier/low-product register B. It returns M (the current multiplier LSB) to the FSM, and drives A/B to the hex displays.

Parameters:
WIDTH, 8, operand width; A, B and S are WIDTH bits, the internal adder is WIDTH+1 bits.

Ports:
Clk  in  1  system clock; all state changes on the rising edge.
Reset  in  1  asynchronous, active-low reset.
Clr_Ld  in  1  load B from S.
Clear_A  in  1  clear A and X.
ADD  in  1  add or subtract S into A (see SUB).
SUB  in  1  qualifies ADD as subtract.
Shift  in  1  arithmetic right shift of {X,A,B}.
S  in  WIDTH  switch input: the multiplier when Clr_Ld is asserted, otherwise the multiplicand.
Aval  out  WIDTH  A register (product high byte).
Bval  out  WIDTH  B register (product low byte).
X  out  1  sign-extension bit.
M  out  1  B[0], combinational, fed to the FSM.

Behaviour:
- Reset low, asynchronous: X=0, A=0, B=0, so M=0. Holding Reset low blocks all strobes. Reset rising takes effect at the next clock edge.
- Adder, combinational, WIDTH+1 bits:
  - operand1 = {A[WIDTH-1],A}; operand2 = {S[WIDTH-1],S}.
  - ADD=1,SUB=0: sum = operand1 + operand2.
  - ADD=1,SUB=1: sum = operand1 + ~operand2 + 1.
  - Carry out of bit WIDTH is discarded.
- Per rising edge, A/X update by priority:
  1. Clear_A: A<=0, X<=0.
  2. else ADD: A<=sum[WIDTH-1:0], X<=sum[WIDTH].
  3. else Shift: A<={X,A[WIDTH-1:1]}; X unchanged.
  4. else hold.
- Per rising edge, B update by priority:
  1. Clr_Ld: B<=S.
  2. else Shift, only if ADD=0 and Clear_A=0: B<={A[0],B[WIDTH-1:1]}, using pre-edge A.
  3. else hold.
- SUB without ADD is a no-op; B is never affected by ADD/SUB.
- Clr_Ld and Clear_A together (idle state) both apply in the same cycle.
- ADD and Shift together is illegal from the FSM. Required behaviour: ADD wins, and A, X and B all skip the shift.
- Latency: each strobe's effect is visible on outputs the cycle after the edge. M tracks B combinationally.
- Full sequence: 7 add/shift pairs, one subtract cycle, a final shift. After that, {Aval,Bval} is the 2·WIDTH-bit two's-complement product of the loaded B and S, and X equals the product sign.
- Width boundaries:
  - S = -2^(WIDTH-1) subtracted from A=0 yields +2^(WIDTH-1) in 9 bits (X=0, A=0x80). This is correct and is not flagged as overflow.
  - The shift must be arithmetic through X, never logical.
- No internal FSM; all sequencing belongs to the control FSM.

Test Plan:
1. Drive Reset low mid-run with A=0x5A, B=0x3C, X=1 -> outputs go to 0x00/0x00/0, M=0, before the next clock edge. Strobes are ignored while Reset is low.
2. Clr_Ld=1, Clear_A=1, S=0x07 for one edge -> B=0x07, A=0x00, X=0, M=1.
3. From A=0, B=0x07, X=0: ADD with S=0x07 -> A=0x07, X=0. Then Shift -> A=0x03, B=0x83, X=0, M=1.
4. Full FSM-order run (load B=0x07, then S=0xFD; 7×(ADD=M, Shift), ADD=SUB=M, Shift) -> A=0xFF, B=0xEB, X=1, i.e. 7×(-3) = -21. Repeat with B=0x80, S=0x80 -> {A,B}=0x4000, X=0.
5. A=0x00, S=0x80, ADD=SUB=1 -> A=0x80, X=0. Then A=0x7F, S=0x01, ADD -> A=0x80, X=0 (9-bit sum 0_1000_0000).
6. Illegal ADD+Shift with A=0x01, B=0x02, S=0x01 -> A=0x02, X=0, B=0x02 (no shift). Clear_A+ADD with A=0x10 -> A=0x00, X=0.

Source files
------------

// File: rtl/multiplier_datapath.sv
// multiplier_datapath: X/A/B registers and 9-bit add/sub for the shift-add signed multiplier
module multiplier_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr_Ld,
    input  logic             Clear_A,
    input  logic             ADD,
    input  logic             SUB,
    input  logic             Shift,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             M
);
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   op1, op2, sum;
    // sign-extended add, or subtract as add of the inverted operand plus one; carry out of the top bit is dropped
    always_comb begin
        op1 = {a_q[WIDTH-1], a_q};
        op2 = SUB ? ~{S[WIDTH-1], S} : {S[WIDTH-1], S};
        sum = op1 + op2 + {{WIDTH{1'b0}}, SUB};
    end
    // next state: clear beats add beats shift for A/X; load beats shift for B, and B skips the shift whenever A is cleared or added
    always_comb begin
        x_d = Clear_A ? 1'b0 : ADD ? sum[WIDTH] : x_q;
        a_d = Clear_A ? '0 : ADD ? sum[WIDTH-1:0] : Shift ? {x_q, a_q[WIDTH-1:1]} : a_q;
        b_d = Clr_Ld ? S : (Shift && !ADD && !Clear_A) ? {a_q[0], b_q[WIDTH-1:1]} : b_q;
    end
    // state registers with asynchronous active-low clear
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end
    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];
endmodule

// File: tb/tb_multiplier_datapath.sv
// tb_multiplier_datapath: directed checks of the multiplier datapath
module tb_multiplier_datapath;
    logic       Clk = 1'b0, Reset = 1'b0;
    logic       Clr_Ld = 1'b0, Clear_A = 1'b0, ADD = 1'b0, SUB = 1'b0, Shift = 1'b0;
    logic [7:0] S = 8'h00;
    logic [7:0] Aval, Bval;
    logic       X, M;
    int         errors = 0, checks = 0;

    multiplier_datapath #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Clr_Ld(Clr_Ld), .Clear_A(Clear_A), .ADD(ADD),
        .SUB(SUB), .Shift(Shift), .S(S), .Aval(Aval), .Bval(Bval), .X(X), .M(M)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] a, input logic [7:0] b, input logic x);
        chk({tag, ".A"}, Aval, a);
        chk({tag, ".B"}, Bval, b);
        chk({tag, ".X"}, {7'd0, X}, {7'd0, x});
        chk({tag, ".M"}, {7'd0, M}, {7'd0, b[0]});
    endtask

    task automatic step(input logic ld, input logic clr, input logic ad, input logic sb,
                        input logic sh, input logic [7:0] s);
        Clr_Ld = ld; Clear_A = clr; ADD = ad; SUB = sb; Shift = sh; S = s;
        @(posedge Clk);
        #1;
        Clr_Ld = 0; Clear_A = 0; ADD = 0; SUB = 0; Shift = 0;
    endtask

    task automatic run_mult(input logic [7:0] b, input logic [7:0] s);
        step(1, 1, 0, 0, 0, b);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, M, 0, 0, s);
            step(0, 0, 0, 0, 1, s);
        end
        step(0, 0, M, M, 0, s);
        step(0, 0, 0, 0, 1, s);
    endtask

    initial begin
        #1;
        chk_all("por", 8'h00, 8'h00, 1'b0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk_all("after_release", 8'h00, 8'h00, 1'b0);
        // test 1: build A=5A B=3C X=1, then async reset
        step(1, 1, 0, 0, 0, 8'h3C);
        step(0, 0, 1, 0, 0, 8'h80);
        step(0, 0, 1, 0, 0, 8'hDA);
        chk_all("pre_reset", 8'h5A, 8'h3C, 1'b1);
        #2 Reset = 1'b0;
        #1;
        chk_all("async_reset", 8'h00, 8'h00, 1'b0);
        Clr_Ld = 1; ADD = 1; Shift = 1; S = 8'h55;
        @(posedge Clk); #1;
        chk_all("reset_blocks", 8'h00, 8'h00, 1'b0);
        Clr_Ld = 0; ADD = 0; Shift = 0;
        Reset = 1'b1;
        // test 2: idle load
        step(1, 1, 0, 0, 0, 8'h07);
        chk_all("load", 8'h00, 8'h07, 1'b0);
        // test 3: add then shift
        step(0, 0, 1, 0, 0, 8'h07);
        chk_all("add7", 8'h07, 8'h07, 1'b0);
        step(0, 0, 0, 0, 1, 8'h07);
        chk_all("shift", 8'h03, 8'h83, 1'b0);
        // SUB alone does nothing
        step(0, 0, 0, 1, 0, 8'h01);
        chk_all("sub_only", 8'h03, 8'h83, 1'b0);
        // test 4: full multiplications
        run_mult(8'h07, 8'hFD);
        chk_all("7x-3", 8'hFF, 8'hEB, 1'b1);
        run_mult(8'h80, 8'h80);
        chk_all("-128x-128", 8'h40, 8'h00, 1'b0);
        run_mult(8'hFD, 8'h07);
        chk_all("-3x7", 8'hFF, 8'hEB, 1'b1);
        run_mult(8'h05, 8'h03);
        chk_all("5x3", 8'h00, 8'h0F, 1'b0);
        run_mult(8'hFF, 8'hFF);
        chk_all("-1x-1", 8'h00, 8'h01, 1'b0);
        // test 5: width boundaries
        step(1, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 0, 8'h80);
        chk_all("0-(-128)", 8'h80, 8'h00, 1'b0);
        step(0, 0, 0, 0, 1, 8'h00);
        chk_all("arith_shift_pos", 8'h40, 8'h00, 1'b0);
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h7F);
        step(0, 0, 1, 0, 0, 8'h01);
        chk_all("7F+1", 8'h80, 8'h00, 1'b0);
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h90);
        step(0, 0, 0, 0, 1, 8'h00);
        chk_all("arith_shift_neg", 8'hC8, 8'h00, 1'b1);
        // test 6: illegal ADD+Shift, Clear_A+ADD
        step(1, 1, 0, 0, 0, 8'h02);
        step(0, 0, 1, 0, 0, 8'h01);
        step(0, 0, 1, 0, 1, 8'h01);
        chk_all("add_shift", 8'h02, 8'h02, 1'b0);
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h10);
        chk_all("a10", 8'h10, 8'h02, 1'b0);
        step(0, 1, 1, 0, 0, 8'h10);
        chk_all("clear_add", 8'h00, 8'h02, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
